param_booth_multiplier: RTL and testbench
=========================================

PARAM_BOOTH_MULTIPLIER -- requirements
Module: param_booth_multiplier

Interface
REQ-001 SHALL have parameter W, default 8, operand width in bits (even, >= 4).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  request a new multiplication, sampled in IDLE or DONE only.
REQ-005 SHALL have port is_signed  input  1  1 = two's-complement operands, 0 = unsigned, captured with start.
REQ-006 SHALL have port x  input  W  multiplicand, captured with start.
REQ-007 SHALL have port y  input  W  multiplier, captured with start.
REQ-008 SHALL have port busy  output  1  high while iterations are in progress.
REQ-009 SHALL have port done  output  1  single-cycle pulse, result valid.
REQ-010 SHALL have port p  output  2W  product, held until the next done.

Function
REQ-011 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE, or DONE -> RUN on start.
REQ-012 SHALL capture x, y and is_signed into internal registers on the edge where start=1 in IDLE or DONE; later input changes have no effect on the running operation.
REQ-013 SHALL extend operands internally to W+2 bits: sign-extend if is_signed=1, zero-extend if 0.
REQ-014 SHALL perform Booth recoding of the extended multiplier over N iterations: radix-2 N=W+2, radix-4 N=(W+2)/2; one iteration per cycle.
REQ-015 SHALL hold busy=1 for exactly N cycles, starting the cycle after start is accepted.
REQ-016 SHALL assert done for exactly one cycle, the cycle after the last iteration; start-to-done latency is N+1 cycles.
REQ-017 SHALL update p in the same cycle done rises, to the low 2W bits of the exact product, and hold it otherwise.
REQ-018 SHALL ignore start while in RUN, with no restart and no corruption of the operation in progress.
REQ-019 SHALL accept start during the DONE cycle, giving back-to-back operations with done spaced N+1 cycles apart.
REQ-020 SHALL produce the exact result for the signed corner -2^(W-1) * -2^(W-1) = 2^(2W-2) and for the unsigned corner (2^W-1)^2.
REQ-021 SHALL handle x=0 or y=0 with the full latency and no early termination.

Reset
REQ-022 SHALL, with rst_n=0 at a clock edge, go to IDLE and set busy=0, done=0, p=0 and the iteration counter to 0, including mid-RUN; the aborted operation produces no done.
REQ-023 SHALL ignore start while rst_n=0.

Configuration
REQ-024 SHALL use macro MULT_RADIX4_EN: when defined, radix-4 Booth (digits -2..+2), N=(W+2)/2; when undefined, radix-2 Booth (digits -1..+1), N=W+2; results are identical in both modes.

Structure
REQ-025 SHALL place the FSM state typedef (IDLE/RUN/DONE) and an iteration-count constant function of W and the radix in shared package mult_pkg.
REQ-026 SHALL isolate Booth digit selection and partial-product generation in sub-module booth_recoder, parametrised by W and the radix macro.

Verification (W=8; latency 11 radix-2, 6 radix-4)
REQ-027 SHALL check signed x=8'h05, y=8'hFB (5*-5) -> p=16'hFFE7 (-25), done exactly N+1 cycles after start, busy high for N cycles.
REQ-028 SHALL check unsigned x=8'hFB, y=8'h05 -> p=16'h04E7 (1255); unsigned 8'hFF*8'hFF -> p=16'hFE01; signed 8'h80*8'h80 -> p=16'h4000.
REQ-029 SHALL check signed 8'hFF*8'hFF -> p=16'h0001, then start in the DONE cycle with 8'hFC*8'h01 -> second done N+1 cycles later, p=16'hFFFC.
REQ-030 SHALL check start pulsed with x=3, y=5 and again mid-RUN with x=7, y=7 -> a single done, p=16'h000F.
REQ-031 SHALL check rst_n=0 on the 3rd RUN cycle -> next cycle busy=0, p=0, no done; a fresh start afterwards completes correctly.
REQ-032 SHALL run random signed and unsigned operands in both macro settings, compared against a behavioural product model.

Source files
------------

// File: rtl/mult_pkg.sv
// mult_pkg -- shared definitions for the Booth multiplier.
//   state_t     : controller states IDLE / RUN / DONE
//   RADIX_SHIFT : multiplier bits retired per iteration (1 = radix-2, 2 = radix-4)
//   iter_count  : number of iterations for a given operand width and shift
// Configuration macro: MULT_RADIX4_EN (defined -> radix-4, undefined -> radix-2).
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

`ifdef MULT_RADIX4_EN
    localparam int unsigned RADIX_SHIFT = 2;
`else
    localparam int unsigned RADIX_SHIFT = 1;
`endif

    // Operands are extended to w+2 bits; each iteration retires 'shift' bits.
    function automatic int unsigned iter_count(input int unsigned w, input int unsigned shift);
        return (w + 2) / shift;
    endfunction

endpackage

// File: rtl/booth_recoder.sv
// booth_recoder -- Booth digit selection and partial-product generation.
//   mcand  : extended multiplicand (W+2 bits, two's complement)
//   window : multiplier bits {q[RADIX_SHIFT-1:0], q_prev} examined this iteration
//   pp     : partial product (W+4 bits, two's complement), digit * mcand
// Configuration macro: MULT_RADIX4_EN (digits -2..+2 when defined, -1..+1 otherwise).
module booth_recoder
    import mult_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [W+1:0]         mcand,
    input  logic [RADIX_SHIFT:0] window,
    output logic [W+3:0]         pp
);

    logic [W+3:0] m_ext;

    // Two guard bits keep +/-2*mcand representable without overflow.
    assign m_ext = {{2{mcand[W+1]}}, mcand};

    always_comb begin
        pp = '0;
`ifdef MULT_RADIX4_EN
        case (window)
            3'b001, 3'b010: pp = m_ext;
            3'b011:         pp = m_ext << 1;
            3'b100:         pp = -(m_ext << 1);
            3'b101, 3'b110: pp = -m_ext;
            default:        pp = '0;
        endcase
`else
        case (window)
            2'b01:   pp = m_ext;
            2'b10:   pp = -m_ext;
            default: pp = '0;
        endcase
`endif
    end

endmodule

// File: rtl/param_booth_multiplier.sv
// param_booth_multiplier -- iterative Booth multiplier, signed or unsigned operands.
//   clk       : clock, all state changes on rising edge
//   rst_n     : synchronous active-low reset
//   start     : request a new multiplication (accepted in IDLE or DONE)
//   is_signed : 1 = two's-complement operands, 0 = unsigned (captured with start)
//   x, y      : multiplicand / multiplier (captured with start)
//   busy      : high while iterations are in progress
//   done      : one-cycle pulse, p valid
//   p         : low 2W bits of the product, held until the next done
// Configuration macro: MULT_RADIX4_EN (radix-4, (W+2)/2 iterations when defined;
// radix-2, W+2 iterations otherwise).
module param_booth_multiplier
    import mult_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           is_signed,
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] p
);

    localparam int unsigned E      = W + 2;
    localparam int unsigned AW     = W + 4;
    localparam int unsigned RS     = RADIX_SHIFT;
    localparam int unsigned N_ITER = iter_count(W, RS);
    localparam int unsigned CW     = $clog2(N_ITER + 1);
    localparam logic [CW-1:0] LAST = CW'(N_ITER - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [E-1:0]  mcand;
    logic [E-1:0]  q;
    logic          q_prev;
    logic [AW-1:0] acc;

    logic [E-1:0]  x_ext;
    logic [E-1:0]  y_ext;
    logic [RS:0]   window;
    logic [AW-1:0] pp;
    logic [AW-1:0] sum;
    logic [AW-1:0] acc_next;
    logic [E-1:0]  q_next;

    assign x_ext  = is_signed ? {{2{x[W-1]}}, x} : {2'b00, x};
    assign y_ext  = is_signed ? {{2{y[W-1]}}, y} : {2'b00, y};
    assign window = {q[RS-1:0], q_prev};

    booth_recoder #(
        .W(W)
    ) u_recoder (
        .mcand  (mcand),
        .window (window),
        .pp     (pp)
    );

    // {acc, q} is one long shift register: the partial product is added to the
    // upper half, then the pair is shifted arithmetically right by RS bits so
    // the low product bits migrate into q as multiplier bits are retired.
    always_comb begin
        sum      = acc + pp;
        acc_next = AW'($signed(sum) >>> RS);
        q_next   = {sum[RS-1:0], q[E-1:RS]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            p      <= '0;
            cnt    <= '0;
            mcand  <= '0;
            q      <= '0;
            q_prev <= 1'b0;
            acc    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mcand  <= x_ext;
                        q      <= y_ext;
                        q_prev <= 1'b0;
                        acc    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    q      <= q_next;
                    q_prev <= q[RS-1];
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        // Low 2W bits of the final {acc, q} are the product.
                        p     <= {acc_next[W-3:0], q_next};
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_param_booth_multiplier.sv
// tb_param_booth_multiplier -- self-checking bench for param_booth_multiplier (W=8).
// Honors MULT_RADIX4_EN to select the expected iteration count.
module tb_param_booth_multiplier;

    localparam int W = 8;
`ifdef MULT_RADIX4_EN
    localparam int N = (W + 2) / 2;
`else
    localparam int N = W + 2;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic           is_signed;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic           busy;
    logic           done;
    logic [2*W-1:0] p;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    param_booth_multiplier #(
        .W(W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .x         (x),
        .y         (y),
        .busy      (busy),
        .done      (done),
        .p         (p)
    );

    typedef struct {
        logic           sg;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2*W-1:0] model(input logic sg, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [2*W-1:0] ea;
        logic [2*W-1:0] eb;
        ea = sg ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
        eb = sg ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
        return ea * eb;
    endfunction

    // Caller is at a falling edge; start is held for one rising edge, then the
    // inputs are scrambled to prove they were captured.
    task automatic launch(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b);
        start     = 1'b1;
        is_signed = sg;
        x         = a;
        y         = b;
        @(negedge clk);
        start     = 1'b0;
        is_signed = ~sg;
        x         = W'($urandom);
        y         = W'($urandom);
    endtask

    // Returns at the falling edge where done is seen; lat counts cycles since
    // the start cycle, bcnt counts busy cycles before done.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 1;
        bcnt = 0;
        while (done !== 1'b1 && lat < 4 * N) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        vec_t           tbl[13];
        int             lat;
        int             bcnt;
        int             cyc;
        int             dones;
        int             first;
        logic [2*W-1:0] res;
        logic           sg;
        logic [W-1:0]   ra;
        logic [W-1:0]   rb;

        tbl[0]  = '{1'b1, 8'h05, 8'hFB, 16'hFFE7};
        tbl[1]  = '{1'b0, 8'hFB, 8'h05, 16'h04E7};
        tbl[2]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
        tbl[3]  = '{1'b1, 8'h80, 8'h80, 16'h4000};
        tbl[4]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
        tbl[5]  = '{1'b0, 8'h00, 8'hFF, 16'h0000};
        tbl[6]  = '{1'b1, 8'h7F, 8'h80, 16'hC080};
        tbl[7]  = '{1'b0, 8'h80, 8'h80, 16'h4000};
        tbl[8]  = '{1'b1, 8'h00, 8'h80, 16'h0000};
        tbl[9]  = '{1'b0, 8'hFF, 8'h00, 16'h0000};
        tbl[10] = '{1'b1, 8'h80, 8'h7F, 16'hC080};
        tbl[11] = '{1'b0, 8'h0C, 8'h0D, 16'h009C};
        tbl[12] = '{1'b1, 8'h80, 8'h01, 16'hFF80};

        rst_n     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        x         = '0;
        y         = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_p",    32'(p),    32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            launch(tbl[i].sg, tbl[i].a, tbl[i].b);
            wait_done(lat, bcnt);
            chk($sformatf("tbl%0d_p", i),    32'(p),    32'(tbl[i].exp));
            chk($sformatf("tbl%0d_lat", i),  32'(lat),  32'(N + 1));
            chk($sformatf("tbl%0d_busy", i), 32'(bcnt), 32'(N));
            @(negedge clk);
            chk($sformatf("tbl%0d_pulse", i), 32'(done), 32'd0);
            chk($sformatf("tbl%0d_hold", i),  32'(p),    32'(tbl[i].exp));
        end

        // Back-to-back: second start issued during the DONE cycle.
        @(negedge clk);
        launch(1'b1, 8'hFF, 8'hFF);
        wait_done(lat, bcnt);
        chk("b2b_first_p",   32'(p),   32'h0001);
        chk("b2b_first_lat", 32'(lat), 32'(N + 1));
        launch(1'b1, 8'hFC, 8'h01);
        wait_done(lat, bcnt);
        chk("b2b_second_p",   32'(p),    32'hFFFC);
        chk("b2b_second_lat", 32'(lat),  32'(N + 1));
        chk("b2b_second_bsy", 32'(bcnt), 32'(N));

        // Start pulsed again mid-RUN must be ignored.
        @(negedge clk);
        launch(1'b0, 8'd3, 8'd5);
        @(negedge clk);
        start = 1'b1;
        x     = 8'd7;
        y     = 8'd7;
        @(negedge clk);
        start = 1'b0;
        cyc   = 3;
        dones = 0;
        first = 0;
        res   = '0;
        repeat (4 * N) begin
            if (done === 1'b1) begin
                dones++;
                if (first == 0) begin
                    first = cyc;
                    res   = p;
                end
            end
            @(negedge clk);
            cyc++;
        end
        chk("midrun_dones", 32'(dones), 32'd1);
        chk("midrun_lat",   32'(first), 32'(N + 1));
        chk("midrun_p",     32'(res),   32'h000F);

        // Reset on the third RUN cycle aborts the operation; start under reset ignored.
        @(negedge clk);
        launch(1'b1, 8'h05, 8'hFB);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        x     = 8'h09;
        y     = 8'h09;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_p",    32'(p),    32'd0);
        @(negedge clk);
        chk("rst_start_ignored", 32'(busy), 32'd0);
        rst_n = 1'b1;
        start = 1'b0;
        dones = 0;
        bcnt  = 0;
        repeat (2 * N) begin
            if (done === 1'b1) dones++;
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
        end
        chk("rst_no_done", 32'(dones), 32'd0);
        chk("rst_no_busy", 32'(bcnt),  32'd0);
        launch(1'b0, 8'h0C, 8'h0D);
        wait_done(lat, bcnt);
        chk("post_rst_p",   32'(p),   32'h009C);
        chk("post_rst_lat", 32'(lat), 32'(N + 1));

        // Random operands against the behavioural product.
        for (int i = 0; i < 24; i++) begin
            sg = i[0];
            ra = W'($urandom);
            rb = W'($urandom);
            @(negedge clk);
            launch(sg, ra, rb);
            wait_done(lat, bcnt);
            chk($sformatf("rnd%0d_p(%0b,%02h,%02h)", i, sg, ra, rb), 32'(p), 32'(model(sg, ra, rb)));
            chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(N + 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
